mips_cpu_bus_arbiter: RTL
=========================

// Module: mips_cpu_bus_arbiter
// PURPOSE
//  Shares the single Avalon-style memory bus (read/write/byteenable/address/writedata,
//  waitrequest, readdata registered 1 cycle after accept) between the CPU instruction-fetch
//  port and the load/store port. One transaction in flight at a time; each requester gets one done pulse.
// PARAMETERS
//  ADDR_W   32  width of requester and bus byte address
// PORTS
//  clk          in   1       clock; everything samples on posedge
//  reset_n      in   1       asynchronous, active-low reset
//  i_req        in   1       fetch request; held until i_done
//  i_addr       in   ADDR_W  fetch byte address (always a read, byteenable 4'b1111)
//  i_done       out  1       one-cycle pulse: fetch complete, i_rdata valid
//  i_rdata      out  32      fetch data; held until next fetch completes
//  d_req        in   1       data request; held until d_done
//  d_we         in   1       1=write, 0=read
//  d_addr       in   ADDR_W  data byte address
//  d_be         in   4       data byteenable
//  d_wdata      in   32      store data
//  d_done       out  1       one-cycle pulse: data access complete, d_rdata valid if read
//  d_rdata      out  32      load data; held until next data read completes
//  avm_read     out  1       bus read strobe
//  avm_write    out  1       bus write strobe
//  avm_address  out  ADDR_W  bus byte address
//  avm_byteenable out 4      bus byteenable
//  avm_writedata out 32      bus store data
//  avm_waitrequest in 1      bus stall; request is accepted on a posedge where it is 0
//  avm_readdata in   32      valid in the cycle after a read is accepted
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 (avm_* strobes, done pulses, rdata regs, address/data regs);
//    owner pointer = DATA. Reset mid-transaction drops it; no done pulse is issued.
//  - FSM IDLE -> BUS -> (write) IDLE | (read) RDATA -> IDLE.
//  - IDLE: if any eligible req, pick a winner, latch its addr/be/wdata/we and the owner, go to BUS.
//    A port whose done is high this cycle is not eligible (its req is stale).
//  - BUS: avm_read = !we_q, avm_write = we_q; exactly one strobe high; address/be/wdata
//    driven from latches and stable while avm_waitrequest=1. On posedge with waitrequest=0:
//    write -> pulse owner done next cycle, go to IDLE; read -> go to RDATA, strobes drop.
//  - RDATA: on posedge, capture avm_readdata into the owner's rdata register and pulse its done; go to IDLE.
//  - Latency with waitrequest=0: read req at cycle n -> done at n+3; write -> done at n+2.
//    Each waitrequest=1 cycle adds one cycle.
//  - Requester must drop req in its done cycle or on the posedge ending it; changing its
//    inputs while req is held is ignored (values latched in IDLE).
//  - Both reqs in the same IDLE cycle: arbitration policy below. A single req always wins.
//  - Strobes never both high; avm_read/avm_write are 0 in IDLE and RDATA.
// CONFIGURATION
//  - MIPS_BUS_ARB_RR_EN defined: round-robin. On a tie, the port not served last wins; pointer
//    updates at every grant.
//  - Undefined: fixed priority. DATA always beats FETCH on a tie; pointer unused.
// STRUCTURE
//  - mips_cpu_bus_pkg: typedef enum arb_state_t {IDLE,BUS,RDATA}; typedef enum owner_t
//    {OWN_FETCH,OWN_DATA}; localparam BE_WORD = 4'b1111.
//  - Sub-module mips_cpu_bus_arb_pick: combinational 2-way picker (reqs, last owner, mode) -> winner.
// TESTING  (bench uses the byte-addressed bus memory model, waitrequest forcible)
//  1 i_req, i_addr=0x100, mem[0x100..0x103]=78 56 34 12, no stall
//    -> avm_read high 1 cycle; i_done at n+3; i_rdata=0x12345678.
//  2 d_req, we=1, addr=0x200, be=4'b0011, wdata=0xAABBCCDD
//    -> d_done at n+2; mem[0x200]=DD, mem[0x201]=CC, mem[0x202..3] unchanged.
//  3 both reqs same cycle, default build -> data served first, fetch next;
//    with MIPS_BUS_ARB_RR_EN and last=DATA -> fetch first.
//  4 waitrequest held 3 cycles during read -> address/strobe stable 4 cycles;
//    done at n+6; data correct.
//  5 reset_n low while in BUS -> next cycle all avm_* and done 0, state IDLE;
//    re-issued request completes normally.
//  6 continuous i_req and d_req for 8 transactions with RR -> strict alternation;
//    never both strobes high (assertion).

Source files
------------

// File: rtl/mips_cpu_bus_pkg.sv
// Shared types for the CPU bus arbiter: FSM states, bus owner encoding and
// the full-word byteenable used by instruction fetches.
package mips_cpu_bus_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUS,
      RDATA
   } arb_state_t;

   typedef enum logic {
      OWN_FETCH,
      OWN_DATA
   } owner_t;

   localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/mips_cpu_bus_arb_pick.sv
// Two-way requester picker. A lone request always wins. On a tie, round-robin
// mode hands the bus to the port not served last; fixed mode favours data.
module mips_cpu_bus_arb_pick
   import mips_cpu_bus_pkg::*;
(
   input  logic   fetch_req,
   input  logic   data_req,
   input  owner_t last_owner,
   input  logic   rr_en,
   output logic   grant_any,
   output owner_t winner
);

   // Winner selection; defaults to data so a fixed-priority tie needs no extra term
   always_comb begin
      grant_any = fetch_req | data_req;
      winner    = OWN_DATA;
      if (fetch_req && !data_req) begin
         winner = OWN_FETCH;
      end else if (fetch_req && data_req && rr_en && (last_owner == OWN_DATA)) begin
         winner = OWN_FETCH;
      end
   end

endmodule

// File: rtl/mips_cpu_bus_arbiter.sv
// mips_cpu_bus_arbiter: shares one Avalon-style memory bus between the
// instruction-fetch port and the load/store port, one transaction in flight.
// Build option: define MIPS_BUS_ARB_RR_EN for round-robin tie-breaking;
// left undefined, the data port wins every tie.
//
// state | meaning
// IDLE  | no transaction; arbitrate eligible requests
// BUS   | strobe on the bus, held until waitrequest is low
// RDATA | read accepted; readdata is captured at the end of this cycle
module mips_cpu_bus_arbiter
   import mips_cpu_bus_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_done,
   output logic [31:0]       i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [3:0]        d_be,
   input  logic [31:0]       d_wdata,
   output logic              d_done,
   output logic [31:0]       d_rdata,
   output logic              avm_read,
   output logic              avm_write,
   output logic [ADDR_W-1:0] avm_address,
   output logic [3:0]        avm_byteenable,
   output logic [31:0]       avm_writedata,
   input  logic              avm_waitrequest,
   input  logic [31:0]       avm_readdata
);

`ifdef MIPS_BUS_ARB_RR_EN
   localparam logic RR_EN = 1'b1;
`else
   localparam logic RR_EN = 1'b0;
`endif

   arb_state_t state;
   owner_t     owner_q;
   owner_t     last_owner;
   logic       we_q;
   logic       fetch_elig;
   logic       data_elig;
   logic       grant_any;
   owner_t     winner;

   // A request seen in its own done cycle is the finished one, not a new one
   assign fetch_elig = i_req & ~i_done;
   assign data_elig  = d_req & ~d_done;

   mips_cpu_bus_arb_pick u_pick (
      .fetch_req  (fetch_elig),
      .data_req   (data_elig),
      .last_owner (last_owner),
      .rr_en      (RR_EN),
      .grant_any  (grant_any),
      .winner     (winner)
   );

   // Transaction FSM with registered bus strobes, done pulses and read data
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         owner_q        <= OWN_DATA;
         last_owner     <= OWN_DATA;
         we_q           <= 1'b0;
         avm_read       <= 1'b0;
         avm_write      <= 1'b0;
         avm_address    <= '0;
         avm_byteenable <= '0;
         avm_writedata  <= '0;
         i_done         <= 1'b0;
         d_done         <= 1'b0;
         i_rdata        <= '0;
         d_rdata        <= '0;
      end else begin
         i_done <= 1'b0;
         d_done <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_any) begin
                  owner_q    <= winner;
                  last_owner <= winner;
                  state      <= BUS;
                  if (winner == OWN_FETCH) begin
                     we_q           <= 1'b0;
                     avm_read       <= 1'b1;
                     avm_write      <= 1'b0;
                     avm_address    <= i_addr;
                     avm_byteenable <= BE_WORD;
                     avm_writedata  <= '0;
                  end else begin
                     we_q           <= d_we;
                     avm_read       <= ~d_we;
                     avm_write      <= d_we;
                     avm_address    <= d_addr;
                     avm_byteenable <= d_be;
                     avm_writedata  <= d_wdata;
                  end
               end
            end
            BUS: begin
               if (!avm_waitrequest) begin
                  avm_read  <= 1'b0;
                  avm_write <= 1'b0;
                  if (we_q) begin
                     if (owner_q == OWN_FETCH) i_done <= 1'b1;
                     else                      d_done <= 1'b1;
                     state <= IDLE;
                  end else begin
                     state <= RDATA;
                  end
               end
            end
            RDATA: begin
               if (owner_q == OWN_FETCH) begin
                  i_rdata <= avm_readdata;
                  i_done  <= 1'b1;
               end else begin
                  d_rdata <= avm_readdata;
                  d_done  <= 1'b1;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
